// File: rtl/coin_encoder.sv
// Front end for the vending FSM: synchronizes and debounces the coin and cancel
// inputs and turns each accepted event into a one-cycle coded strobe on in1/in2.
module coin_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int JAM_CYCLES      = 5000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic start,
  input  logic coin5_raw,
  input  logic coin10_raw,
  input  logic coin25_raw,
  input  logic cancel_raw,
  input  logic vend_done,
  output logic in1,
  output logic in2,
  output logic controle,
  output logic txn_open,
  output logic err_overrun,
  output logic err_jam
);

  localparam int SRC_N = 4;
  localparam int S5    = 0;
  localparam int S10   = 1;
  localparam int S25   = 2;
  localparam int SCAN  = 3;

  localparam int                DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  JAM_LAST = CNT_W'(JAM_CYCLES - 1);
  localparam logic [CNT_W-1:0]  JAM_MAX  = CNT_W'(JAM_CYCLES);

  logic [SRC_N-1:0] w_raw;
  logic [SRC_N-1:0] w_rise;
  logic [SRC_N-1:0] w_evt;
  logic [SRC_N-1:0] w_clr;
  logic [2:0]       w_jammed;

  logic [SRC_N-1:0] r_pend;
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_in1;
  logic             r_in2;
  logic             r_controle;
  logic             r_txn_open;
  logic             r_err_overrun;

  logic             w_fire;
  logic [1:0]       w_code;
  logic             w_coin_vis;
  logic             w_open_eff;
  logic             w_timeout;

  assign w_raw = {cancel_raw, coin25_raw, coin10_raw, coin5_raw};

  genvar gi;
  generate
    for (gi = 0; gi < SRC_N; gi++) begin : g_src
      logic            r_sync1;
      logic            r_sync2;
      logic            r_deb;
      logic            r_deb_d;
      logic            r_armed;
      logic [DB_W-1:0] r_db_cnt;
      logic [DB_W-1:0] r_arm_cnt;

      always_ff @(posedge clk) begin
        if (start) begin
          r_sync1   <= 1'b0;
          r_sync2   <= 1'b0;
          r_deb     <= 1'b0;
          r_deb_d   <= 1'b0;
          r_armed   <= 1'b0;
          r_db_cnt  <= '0;
          r_arm_cnt <= '0;
        end else begin
          r_sync1 <= w_raw[gi];
          r_sync2 <= r_sync1;
          r_deb_d <= r_deb;
          if (r_sync2 != r_deb) begin
            if (r_db_cnt == DB_LAST) begin
              r_deb    <= r_sync2;
              r_db_cnt <= '0;
            end else begin
              r_db_cnt <= r_db_cnt + 1'b1;
            end
          end else begin
            r_db_cnt <= '0;
          end
          // A level already high out of reset must be seen settled low before it may fire.
          if (!r_armed) begin
            if (!r_deb && !r_sync2) begin
              if (r_arm_cnt == DB_LAST) begin
                r_armed <= 1'b1;
              end else begin
                r_arm_cnt <= r_arm_cnt + 1'b1;
              end
            end else begin
              r_arm_cnt <= '0;
            end
          end
        end
      end

      assign w_rise[gi] = r_deb & ~r_deb_d & r_armed;

      if (gi < 3) begin : g_jam
        logic [CNT_W-1:0] r_jam_cnt;
        logic             r_jammed;

        always_ff @(posedge clk) begin
          if (start) begin
            r_jam_cnt <= '0;
            r_jammed  <= 1'b0;
          end else if (r_deb) begin
            if (r_jam_cnt != JAM_MAX) begin
              r_jam_cnt <= r_jam_cnt + 1'b1;
            end
            if (r_jam_cnt == JAM_LAST) begin
              r_jammed <= 1'b1;
            end
          end else begin
            r_jam_cnt <= '0;
            r_jammed  <= 1'b0;
          end
        end

        assign w_jammed[gi] = r_jammed;
      end
    end
  endgenerate

  assign w_evt = w_rise & {1'b1, ~w_jammed};

  // A coin strobe on the outputs opens the transaction one cycle later; treat it as open already.
  assign w_coin_vis = r_controle & (r_in1 | r_in2);
  assign w_open_eff = r_txn_open | w_coin_vis;
  assign w_timeout  = w_open_eff & ~vend_done & (r_pend == '0) & (r_to_cnt == TO_LAST);

  always_comb begin
    w_clr  = '0;
    w_fire = 1'b0;
    w_code = 2'b00;
    if (r_pend[S25]) begin
      w_clr[S25] = 1'b1;
      w_fire     = 1'b1;
      w_code     = 2'b11;
    end else if (r_pend[S10]) begin
      w_clr[S10] = 1'b1;
      w_fire     = 1'b1;
      w_code     = 2'b10;
    end else if (r_pend[S5]) begin
      w_clr[S5] = 1'b1;
      w_fire    = 1'b1;
      w_code    = 2'b01;
    end else if (r_pend[SCAN]) begin
      w_clr[SCAN] = 1'b1;
      w_fire      = w_open_eff;
    end else if (w_timeout) begin
      w_fire = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      r_pend        <= '0;
      r_to_cnt      <= '0;
      r_in1         <= 1'b0;
      r_in2         <= 1'b0;
      r_controle    <= 1'b0;
      r_txn_open    <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_pend        <= (r_pend & ~w_clr) | w_evt;
      r_err_overrun <= |(w_evt & r_pend & ~w_clr);
      r_controle    <= w_fire;
      r_in1         <= w_fire & w_code[1];
      r_in2         <= w_fire & w_code[0];
      if (r_controle) begin
        r_txn_open <= r_in1 | r_in2;
      end else if (vend_done) begin
        r_txn_open <= 1'b0;
      end
      if (w_fire || vend_done) begin
        r_to_cnt <= '0;
      end else if (w_open_eff && (r_pend == '0) && (r_to_cnt != '1)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign in1         = r_in1;
  assign in2         = r_in2;
  assign controle    = r_controle;
  assign txn_open    = r_txn_open;
  assign err_overrun = r_err_overrun;
  assign err_jam     = |w_jammed;

endmodule
